// File: rtl/gpio_in_filter13.sv
// Per-pin GPIO input conditioning: two-flop synchroniser plus an optional debouncer
// paced by a shared tick prescaler. Define GPIO_FILT_EDGE_EN to add per-pin rise/fall pulse outputs.
module gpio_in_filter13 #(
  parameter int WIDTH   = 16,
  parameter int CNT_W   = 4,
  parameter int PRESC_W = 8
) (
  input  logic               pclk13,
  input  logic               n_p_reset13,
  input  logic [WIDTH-1:0]   pin_raw13,
  input  logic [WIDTH-1:0]   filt_en13,
  input  logic [CNT_W-1:0]   filt_len13,
  input  logic [PRESC_W-1:0] presc13,
  output logic [WIDTH-1:0]   pin_filt13,
  output logic               pin_change13
`ifdef GPIO_FILT_EDGE_EN
  ,
  output logic [WIDTH-1:0]   pin_rise13,
  output logic [WIDTH-1:0]   pin_fall13
`endif
);

  logic [WIDTH-1:0]            sync1_q, sync2_q;
  logic [WIDTH-1:0]            cand_q, cand_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [PRESC_W-1:0]          pcnt_q, pcnt_d;
  logic [WIDTH-1:0]            filt_q, filt_d;
  logic                        change_q, change_d;
  logic                        tick;

  // The >= compare makes a mid-count drop of presc13 tick immediately instead of wrapping.
  assign tick   = (pcnt_q >= presc13);
  assign pcnt_d = tick ? '0 : pcnt_q + 1'b1;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    filt_d = filt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] != cand_q[i]) begin
        cand_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else if (tick && (cnt_q[i] < filt_len13)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (tick && filt_en13[i]) begin
        filt_d[i] = cand_q[i];
      end
      // Bypassed pins follow the synchroniser; cand/cnt keep tracking underneath.
      if (!filt_en13[i]) begin
        filt_d[i] = sync2_q[i];
      end
    end
  end

  assign change_d = |(filt_d ^ filt_q);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge pclk13 or negedge n_p_reset13) begin
    if (!n_p_reset13) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      // NOTE: the counter array is small flop storage, not RAM, so it is reset with everything else.
      cnt_q    <= '0;
      pcnt_q   <= '0;
      filt_q   <= '0;
      change_q <= 1'b0;
    end else begin
      sync1_q  <= pin_raw13;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      pcnt_q   <= pcnt_d;
      filt_q   <= filt_d;
      change_q <= change_d;
    end
  end

  assign pin_filt13   = filt_q;
  assign pin_change13 = change_q;

`ifdef GPIO_FILT_EDGE_EN
  logic [WIDTH-1:0] rise_q, fall_q;

  always_ff @(posedge pclk13 or negedge n_p_reset13) begin
    if (!n_p_reset13) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= filt_d & ~filt_q;
      fall_q <= ~filt_d & filt_q;
    end
  end

  assign pin_rise13 = rise_q;
  assign pin_fall13 = fall_q;
`endif

endmodule
